// File: rtl/hd_clock_gate_ctrl.sv
// Clock-gating controller: turns a functional enable into a glitch-free gated clock,
// with an idle run before gating and a fixed wake-up interval before RDY.
module hd_clock_gate_ctrl #(
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic       CK,
  input  logic       R,
  input  logic       EN,
  input  logic       TE,
  output logic       GCK,
  output logic       RDY,
  output logic       ACTIVE,
  output logic [7:0] WAKE_CNT
);

  // state | meaning
  // OFF   | branch gated, waiting for EN
  // WAKE  | gate open, counting WAKE_CYCLES before RDY
  // RUN   | clock running, RDY given to requester
  // DRAIN | EN dropped, counting IDLE_CYCLES before gating

  typedef enum logic [1:0] {S_OFF, S_WAKE, S_RUN, S_DRAIN} state_t;

  localparam logic [CNT_W-1:0] WAKE_TC = CNT_W'(WAKE_CYCLES);
  localparam logic [CNT_W-1:0] IDLE_TC = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               en_q, en_d;
  logic               rdy_q, rdy_d;
  logic [7:0]         wake_cnt_q, wake_cnt_d;
  logic               gate_lat;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wake_cnt_d = wake_cnt_q;
    case (state_q)
      S_OFF: begin
        if (EN) begin
          state_d = S_WAKE;
          cnt_d   = CNT_ONE;
          if (wake_cnt_q != 8'hFF) wake_cnt_d = wake_cnt_q + 8'd1;
        end
      end
      S_WAKE: begin
        if (cnt_q == WAKE_TC) state_d = S_RUN;
        else                  cnt_d   = cnt_q + CNT_ONE;
      end
      S_RUN: begin
        if (!EN) begin
          state_d = S_DRAIN;
          cnt_d   = CNT_ONE;
        end
      end
      S_DRAIN: begin
        // a returning request wins over the terminal count
        if (EN) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else if (cnt_q == IDLE_TC) begin
          state_d = S_OFF;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_OFF;
    endcase
    en_d  = (state_d != S_OFF);
    rdy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
  end

  always_ff @(posedge CK or posedge R) begin
    if (R) begin
      state_q    <= S_OFF;
      cnt_q      <= '0;
      en_q       <= 1'b0;
      rdy_q      <= 1'b0;
      wake_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      rdy_q      <= rdy_d;
      wake_cnt_q <= wake_cnt_d;
    end
  end

  // Transparent only while CK is low, so enable changes never clip a high phase.
  always_latch begin
    if (R)        gate_lat = 1'b0;
    else if (!CK) gate_lat = en_q | TE;
  end

  assign GCK      = CK & gate_lat;
  assign RDY      = rdy_q;
  assign ACTIVE   = en_q;
  assign WAKE_CNT = wake_cnt_q;

endmodule

// File: doc/hd_clock_gate_ctrl.md
# hd_clock_gate_ctrl

- Clock-gating controller that sits directly upstream of the clock-load / antenna cells on a gated clock branch and produces the gated clock GCK that feeds them.
- Turns a functional enable request into a glitch-free gated clock.
- Uses hysteresis: the branch is gated only after a programmable run of idle cycles, and re-enabled through a fixed wake-up interval before RDY is given back to the requester.

## Interface
Parameters:
- IDLE_CYCLES, 8, consecutive idle edges in DRAIN before gating (1..2^CNT_W-1)
- WAKE_CYCLES, 2, edges spent in WAKE before RDY (1..2^CNT_W-1)
- CNT_W, 4, width of the shared hysteresis counter

Ports:
- CK  input  1  clock (branch root)
- R  input  1  reset: asynchronous, active-high
- EN  input  1  functional clock request (synchronous to CK)
- TE  input  1  test enable; forces GCK on and does not affect the FSM
- GCK  output  1  gated clock = CK AND lat, where lat is a latch transparent while CK is low
- RDY  output  1  branch clock is running and stable for the requester
- ACTIVE  output  1  registered gate enable en_q (1 in RUN, DRAIN, WAKE)
- WAKE_CNT  output  8  saturating count of OFF→WAKE transitions

## Operation
- FSM states are OFF, WAKE, RUN and DRAIN. All registers update on the CK rising edge.
- Reset values (R=1, asynchronous):
  - state=OFF, cnt=0, en_q=0, RDY=0, WAKE_CNT=0
  - latch cleared, so GCK=0 immediately
- OFF: en_q=0, RDY=0.
  - EN=1 → WAKE, cnt=1, WAKE_CNT+=1 (holds at 255).
- WAKE: en_q=1, RDY=0.
  - If cnt==WAKE_CYCLES → RUN; otherwise cnt++.
  - EN is ignored in WAKE. A request dropped mid-wake still completes the wake, then enters RUN; RUN sees EN=0 on the next edge.
- RUN: en_q=1, RDY=1.
  - EN=0 → DRAIN, cnt=1.
- DRAIN: en_q=1, RDY=1.
  - EN=1 → RUN, cnt=0.
  - Otherwise, if cnt==IDLE_CYCLES → OFF; otherwise cnt++.
- RDY and ACTIVE are decoded from registered state only and are glitch-free.
- Gate latch:
  - lat follows (en_q | TE) while CK=0 and holds while CK=1.
  - GCK never produces a partial high pulse from en_q or TE changes.
- Counter:
  - cnt is CNT_W bits and never wraps, because both parameter bounds are < 2^CNT_W.
  - IDLE_CYCLES=1 gates on the edge after DRAIN entry.
- WAKE_CNT: 8-bit counter that saturates at 255 and does not wrap.

## Timing
- Gate latency: an en_q change at rising edge k takes effect on GCK from edge k+1.
  - The first/last gated pulse is at edge k+1 for on/off.
  - The pulse at edge k itself is governed by the previous en_q.
- Wake latency: EN=1 sampled at edge 0 in OFF gives:
  - WAKE after edge 0
  - first GCK pulse at edge 1
  - RDY=1 after edge WAKE_CYCLES
- Gate-off latency:
  - Sampled pattern: EN=0 at edge 0 in RUN, then EN=0 on every following edge.
  - The FSM enters DRAIN at edge 0 and OFF at edge IDLE_CYCLES.
  - The last GCK pulse is at edge IDLE_CYCLES; there is none at edge IDLE_CYCLES+1.
- Simultaneous events:
  - The DRAIN exit on EN=1 takes priority over the terminal count.
  - TE has no priority interaction with the FSM.
- Reset mid-operation:
  - GCK falls asynchronously; a truncated high phase is accepted.
  - After R deasserts, the FSM is in OFF and needs a full wake sequence.
- R deassertion is synchronous to CK by the system; no internal synchronizer.

## Test plan
All scenarios use the defaults (IDLE_CYCLES=8, WAKE_CYCLES=2).
- Reset: assert R while in RUN with CK high → GCK=0 within the same phase, RDY=0, ACTIVE=0, WAKE_CNT=0; after release with EN=0 for 20 cycles → zero GCK pulses.
- Wake: from OFF, EN=1 sampled at edge 0 → first GCK pulse at edge 1, RDY=1 after edge 2, WAKE_CNT=1; drop EN after edge 0 → RUN is still reached after edge 2, then DRAIN.
- Idle gating: in RUN, EN=0 from edge 0 onward → RDY stays 1 through edge 7, OFF after edge 8, last GCK pulse at edge 8, none at edge 9, RDY=0 and ACTIVE=0.
- Re-arm: in RUN, EN=0 at edges 0–4 and EN=1 at edge 5 → RUN after edge 5, GCK never stops, RDY constant 1, WAKE_CNT unchanged.
- Test bypass: in OFF, TE=1 for 10 cycles → 10 GCK pulses, RDY=0, state OFF; TE falling while CK=1 → no truncated pulse.
- Saturation: 300 OFF→WAKE→RUN→DRAIN→OFF round trips → WAKE_CNT=255 and holds.
